uart_music_ctrl: RTL and testbench

- Sequences the shared uart_bus for the music player. Loads a fixed-length note table from UART RX into note RAM, then returns an ACK byte and switches to play mode.
- Arbitrates the single UART TX channel between the load-complete ACK and the picture-switch request.
- Sits between uart_bus, note RAM and the music/picture logic; replaces ad-hoc W_EN/back_music glue.

---
 rtl/uart_music_pkg.sv | 18 +
 rtl/uart_tx_arb.sv | 71 +++++++
 rtl/uart_music_ctrl.sv | 147 ++++++++++++++
 tb/tb_uart_music_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_music_pkg.sv
// Shared definitions for the music-player UART controller.
//   state_e            : controller state encoding
//   SIZE_MUSIC_MAX_DEF : note bytes in one table load
//   ACK_BYTE_DEF       : byte sent on load completion / picture switch
//   RELOAD_BYTE_DEF    : RX byte that restarts loading while playing
package uart_music_pkg;

    typedef enum logic [1:0] {
        ST_LOAD     = 2'd0,
        ST_WAIT_ACK = 2'd1,
        ST_PLAY     = 2'd2
    } state_e;

    localparam int         SIZE_MUSIC_MAX_DEF = 83;
    localparam logic [7:0] ACK_BYTE_DEF       = 8'd66;
    localparam logic [7:0] RELOAD_BYTE_DEF    = 8'd82;

endpackage

// File: rtl/uart_tx_arb.sv
// Arbiter for the single UART TX channel.
//   clk_i, rst_ni       : clock, async active-low reset
//   ack_req_i           : one-cycle request for the load-complete ACK
//   sw_req_i            : one-cycle request for a picture switch
//   tx_data_valid_o     : one-cycle strobe to uart_bus
//   tx_data_in_o        : byte sent with the strobe (holds between strobes)
//   ack_issued_o        : combinational; high on the cycle the ACK is chosen,
//                         which is the cycle before tx_data_valid_o rises
module uart_tx_arb #(
    parameter int         TX_GAP   = 1042,
    parameter logic [7:0] ACK_BYTE = 8'd66
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       ack_req_i,
    input  logic       sw_req_i,
    output logic       tx_data_valid_o,
    output logic [7:0] tx_data_in_o,
    output logic       ack_issued_o
);

    localparam int GAP_W = $clog2(TX_GAP + 1);

    logic             ack_pend_q, ack_pend_d;
    logic             sw_pend_q,  sw_pend_d;
    logic [GAP_W-1:0] gap_q,      gap_d;
    logic             tx_valid_q, tx_valid_d;
    logic [7:0]       tx_data_q,  tx_data_d;
    logic             issue, issue_ack, issue_sw;

    always_comb begin
        issue     = (gap_q == '0) && (ack_pend_q || sw_pend_q);
        issue_ack = issue && ack_pend_q;
        issue_sw  = issue && !ack_pend_q;

        // A request arriving on the issue cycle survives the clear.
        ack_pend_d = (ack_pend_q && !issue_ack) || ack_req_i;
        sw_pend_d  = (sw_pend_q  && !issue_sw)  || sw_req_i;

        gap_d = gap_q;
        if (issue) begin
            gap_d = GAP_W'(TX_GAP - 1);
        end else if (gap_q != '0) begin
            gap_d = gap_q - GAP_W'(1);
        end

        tx_valid_d = issue;
        tx_data_d  = issue ? ACK_BYTE : tx_data_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ack_pend_q <= 1'b0;
            sw_pend_q  <= 1'b0;
            gap_q      <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'd0;
        end else begin
            ack_pend_q <= ack_pend_d;
            sw_pend_q  <= sw_pend_d;
            gap_q      <= gap_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign tx_data_valid_o = tx_valid_q;
    assign tx_data_in_o    = tx_data_q;
    assign ack_issued_o    = issue_ack;

endmodule

// File: rtl/uart_music_ctrl.sv
// Music-player UART sequencer: loads a note table from RX into note RAM,
// acknowledges on TX, then enables playback until a reload byte arrives.
//   clk_i, rst_ni        : clock, async active-low reset
//   rx_data_valid_i/out_i: received byte strobe and data from uart_bus
//   sw_req_i             : picture-switch request level (rising edge = 1 req)
//   tx_data_valid_o/in_o : transmit strobe and byte to uart_bus
//   wr_en_o/addr_o/data_o: note RAM write port (1 cycle after RX strobe)
//   play_en_o            : high while playing
//   load_done_o          : pulse on entry to PLAY
//   fmt_err_o            : sticky, a loaded byte had bits above NOTE_W set
//
// state    | meaning
// ---------+-----------------------------------------------------------
// LOAD     | writing RX bytes to note RAM at index, index 0..SIZE-1
// WAIT_ACK | table full, RX ignored, waiting for the ACK to go out
// PLAY     | player enabled, only RELOAD_BYTE is acted on
module uart_music_ctrl
    import uart_music_pkg::*;
#(
    parameter int         SIZE_MUSIC_MAX = SIZE_MUSIC_MAX_DEF,
    parameter int         ADDR_W         = 8,
    parameter int         NOTE_W         = 5,
    parameter logic [7:0] ACK_BYTE       = ACK_BYTE_DEF,
    parameter logic [7:0] RELOAD_BYTE    = RELOAD_BYTE_DEF,
    parameter int         TX_GAP         = 1042
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              rx_data_valid_i,
    input  logic [7:0]        rx_data_out_i,
    input  logic              sw_req_i,
    output logic              tx_data_valid_o,
    output logic [7:0]        tx_data_in_o,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [NOTE_W-1:0] wr_data_o,
    output logic              play_en_o,
    output logic              load_done_o,
    output logic              fmt_err_o
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(SIZE_MUSIC_MAX - 1);

    state_e            state_q,     state_d;
    logic [ADDR_W-1:0] index_q,     index_d;
    logic              wr_en_q,     wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q,   wr_addr_d;
    logic [NOTE_W-1:0] wr_data_q,   wr_data_d;
    logic              fmt_err_q,   fmt_err_d;
    logic              load_done_q, load_done_d;
    logic              sw_q;
    logic              ack_req, sw_rise, ack_issued;

    assign sw_rise = sw_req_i && !sw_q;

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        fmt_err_d   = fmt_err_q;
        load_done_d = 1'b0;
        ack_req     = 1'b0;

        unique case (state_q)
            ST_LOAD: begin
                if (rx_data_valid_i) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = index_q;
                    wr_data_d = rx_data_out_i[NOTE_W-1:0];
                    if (rx_data_out_i[7:NOTE_W] != '0) begin
                        fmt_err_d = 1'b1;
                    end
                    if (index_q == LAST_IDX) begin
                        index_d = '0;
                        ack_req = 1'b1;
                        state_d = ST_WAIT_ACK;
                    end else begin
                        index_d = index_q + ADDR_W'(1);
                    end
                end
            end
            ST_WAIT_ACK: begin
                // Registered with tx_data_valid, so both rise together.
                if (ack_issued) begin
                    state_d     = ST_PLAY;
                    load_done_d = 1'b1;
                end
            end
            ST_PLAY: begin
                if (rx_data_valid_i && (rx_data_out_i == RELOAD_BYTE)) begin
                    state_d   = ST_LOAD;
                    index_d   = '0;
                    fmt_err_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_LOAD;
                index_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_LOAD;
            index_q     <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            fmt_err_q   <= 1'b0;
            load_done_q <= 1'b0;
            sw_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            fmt_err_q   <= fmt_err_d;
            load_done_q <= load_done_d;
            sw_q        <= sw_req_i;
        end
    end

    uart_tx_arb #(
        .TX_GAP   (TX_GAP),
        .ACK_BYTE (ACK_BYTE)
    ) u_tx_arb (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .ack_req_i       (ack_req),
        .sw_req_i        (sw_rise),
        .tx_data_valid_o (tx_data_valid_o),
        .tx_data_in_o    (tx_data_in_o),
        .ack_issued_o    (ack_issued)
    );

    assign wr_en_o     = wr_en_q;
    assign wr_addr_o   = wr_addr_q;
    assign wr_data_o   = wr_data_q;
    assign play_en_o   = (state_q == ST_PLAY);
    assign load_done_o = load_done_q;
    assign fmt_err_o   = fmt_err_q;

endmodule

// File: tb/tb_uart_music_ctrl.sv
module tb_uart_music_ctrl;

    localparam int TX_GAP = 100;
    localparam int NBYTES = 83;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'd0;
    logic       sw_req = 1'b0;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [4:0] wr_data;
    logic       play_en;
    logic       load_done;
    logic       fmt_err;

    uart_music_ctrl #(.TX_GAP(TX_GAP)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .rx_data_valid_i (rx_valid),
        .rx_data_out_i   (rx_data),
        .sw_req_i        (sw_req),
        .tx_data_valid_o (tx_valid),
        .tx_data_in_o    (tx_data),
        .wr_en_o         (wr_en),
        .wr_addr_o       (wr_addr),
        .wr_data_o       (wr_data),
        .play_en_o       (play_en),
        .load_done_o     (load_done),
        .fmt_err_o       (fmt_err)
    );

    always #5 clk = ~clk;

    typedef struct {int addr; int data;} wr_t;
    typedef struct {int val; bit is_ack; int spacing;} tx_t;

    wr_t wr_q[$];
    tx_t tx_q[$];

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;
    int last_tx_cyc = 0;
    logic play_prev = 1'b0;

    // reference model state
    int model_mode = 0;   // 0 load, 2 play
    int model_idx  = 0;
    bit model_fmt  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en) begin
                if (wr_q.size() == 0) begin
                    check("wr_spurious", {31'd0, wr_en}, 32'd0);
                end else begin
                    wr_t e;
                    e = wr_q.pop_front();
                    check("wr_addr", {24'd0, wr_addr}, e.addr);
                    check("wr_data", {27'd0, wr_data}, e.data);
                end
            end
            if (tx_valid) begin
                if (tx_q.size() == 0) begin
                    check("tx_spurious", {31'd0, tx_valid}, 32'd0);
                end else begin
                    tx_t t;
                    t = tx_q.pop_front();
                    check("tx_byte", {24'd0, tx_data}, t.val);
                    if (t.is_ack) begin
                        check("ack_load_done", {31'd0, load_done}, 32'd1);
                        check("ack_play_en", {31'd0, play_en}, 32'd1);
                        check("ack_play_prev", {31'd0, play_prev}, 32'd0);
                    end
                    if (t.spacing != 0)
                        check("tx_spacing", cyc - last_tx_cyc, t.spacing);
                end
                last_tx_cyc = cyc;
            end else if (load_done) begin
                check("load_done_alone", {31'd0, load_done}, 32'd0);
            end
            play_prev = play_en;
        end
    end

    task automatic model_byte(input logic [7:0] b, input bit with_sw);
        tx_t t;
        if (model_mode == 0) begin
            wr_q.push_back('{addr: model_idx, data: int'(b[4:0])});
            if (b[7:5] != 3'd0) model_fmt = 1;
            if (model_idx == NBYTES - 1) begin
                model_idx = 0;
                // the ACK goes out two cycles later, well before the next byte
                model_mode = 2;
                t = '{val: 66, is_ack: 1'b1, spacing: 0};
                tx_q.push_back(t);
                if (with_sw) begin
                    t = '{val: 66, is_ack: 1'b0, spacing: TX_GAP};
                    tx_q.push_back(t);
                end
            end else begin
                model_idx++;
            end
        end else if (b == 8'd82) begin
            model_mode = 0;
            model_idx  = 0;
            model_fmt  = 0;
        end
    endtask

    // one byte per 10-bit frame at 10 cycles/bit
    task automatic send_byte(input logic [7:0] b, input bit with_sw);
        repeat (99) @(posedge clk);
        #1;
        rx_valid = 1'b1;
        rx_data  = b;
        if (with_sw) sw_req = 1'b1;
        model_byte(b, with_sw);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_valid"},  {31'd0, tx_valid},  32'd0);
        check({tag, "_tx_data"},   {24'd0, tx_data},   32'd0);
        check({tag, "_wr_en"},     {31'd0, wr_en},     32'd0);
        check({tag, "_wr_addr"},   {24'd0, wr_addr},   32'd0);
        check({tag, "_wr_data"},   {27'd0, wr_data},   32'd0);
        check({tag, "_play_en"},   {31'd0, play_en},   32'd0);
        check({tag, "_load_done"}, {31'd0, load_done}, 32'd0);
        check({tag, "_fmt_err"},   {31'd0, fmt_err},   32'd0);
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_wr_left"}, wr_q.size(), 32'd0);
        check({tag, "_tx_left"}, tx_q.size(), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst_n = 1'b1;

        // load 0..82 with one out-of-range byte at index 5
        for (int i = 0; i < NBYTES; i++)
            send_byte((i == 5) ? 8'hE3 : 8'(i), 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("load1_play_en", {31'd0, play_en}, 32'd1);
        check("load1_fmt_err", {31'd0, fmt_err}, {31'd0, model_fmt});
        check_drained("load1");

        // extra bytes while playing are ignored
        send_byte(8'h01, 1'b0);
        send_byte(8'h10, 1'b0);
        send_byte(8'h7F, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_byte(8'h00, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("extra_fmt_err", {31'd0, fmt_err}, 32'd1);
        check("extra_play_en", {31'd0, play_en}, 32'd1);
        check_drained("extra");

        // reload, then a second table with a switch request on the last byte
        send_byte(8'd82, 1'b0);
        #1;
        check("reload_play_en", {31'd0, play_en}, 32'd0);
        check("reload_fmt_err", {31'd0, fmt_err}, 32'd0);
        for (int i = 0; i < NBYTES - 1; i++)
            send_byte(8'((i * 7 + 3) & 8'h1F), 1'b0);
        send_byte(8'h11, 1'b1);
        repeat (3) @(posedge clk);
        sw_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            repeat (7) @(posedge clk);
            #1 sw_req = 1'b1;
            repeat (3) @(posedge clk);
            #1 sw_req = 1'b0;
        end
        repeat (3 * TX_GAP) @(posedge clk);
        #1;
        check("load2_fmt_err", {31'd0, fmt_err}, 32'd0);
        check_drained("contention");

        // reload and reset part-way through
        send_byte(8'd82, 1'b0);
        for (int i = 0; i < 40; i++)
            send_byte(8'(i + 9), 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        model_mode = 0;
        model_idx  = 0;
        model_fmt  = 0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("midrst");
        check_drained("midrst");
        rst_n = 1'b1;

        for (int i = 0; i < NBYTES; i++)
            send_byte(8'((NBYTES - i) | 8'h20), 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("load3_play_en", {31'd0, play_en}, 32'd1);
        check("load3_fmt_err", {31'd0, fmt_err}, {31'd0, model_fmt});
        check_drained("load3");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
